// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: round-robin arbiter that shares one I2C master engine
// between two requesters and routes each transaction to bus 1 or bus 2.
// Optional build macro: I2C_SCHED_TIMEOUT_EN (WAIT_DONE watchdog with m_abort).
module i2c_txn_scheduler #(
  parameter int unsigned BUS_FREE_CYCLES = 64,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic       req0_rw,
  input  logic [7:0] req0_wdata,
  input  logic       req0_bus,
  output logic       resp0_valid,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic       req1_rw,
  input  logic [7:0] req1_wdata,
  input  logic       req1_bus,
  output logic       resp1_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_nack,
  output logic       resp_timeout,
  output logic       m_start,
  output logic       m_abort,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_wdata,
  output logic       m_bus_sel,
  input  logic       m_done,
  input  logic [7:0] m_rdata,
  input  logic       m_nack,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND,
    GAP
  } state_t;

  localparam int unsigned GAP_W = (BUS_FREE_CYCLES > 2) ? $clog2(BUS_FREE_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (BUS_FREE_CYCLES == 0) ? '0 : GAP_W'(BUS_FREE_CYCLES - 1);

  state_t           state;
  logic             last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic             any_valid;
  logic             winner;
  logic             tmo_hit;

  // On a tie the requester that was not served last wins.
  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign busy      = (state != IDLE);

`ifdef I2C_SCHED_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        abort_q;
  logic        tmo_q;

  // A done on the terminal-count cycle wins over the abort.
  assign tmo_hit      = (state == WAIT_DONE) && !m_done && (tcnt == TIMEOUT_CYCLES - 16'd1);
  assign m_abort      = abort_q;
  assign resp_timeout = tmo_q;

  // Watchdog counter over WAIT_DONE plus the abort pulse and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt    <= '0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      abort_q <= tmo_hit;
      if (state == ISSUE)
        tcnt <= '0;
      else if (state == WAIT_DONE)
        tcnt <= tcnt + 16'd1;
      if (tmo_hit)
        tmo_q <= 1'b1;
      else if ((state == WAIT_DONE) && m_done)
        tmo_q <= 1'b0;
    end
  end
`else
  // The timeout limit only matters in the watchdog build; it stays referenced here.
  assign tmo_hit      = 1'b0 & (TIMEOUT_CYCLES == 16'd0);
  assign m_abort      = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  // Transaction sequencer with registered handshake pulses and descriptor latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gap_cnt     <= '0;
      grant_id    <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_rdata  <= '0;
      resp_nack   <= 1'b0;
      m_start     <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_wdata     <= '0;
      m_bus_sel   <= 1'b0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      m_start     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            if (winner) begin
              req1_ready <= 1'b1;
              m_addr     <= req1_addr;
              m_rw       <= req1_rw;
              m_wdata    <= req1_wdata;
              m_bus_sel  <= req1_bus;
            end else begin
              req0_ready <= 1'b1;
              m_addr     <= req0_addr;
              m_rw       <= req0_rw;
              m_wdata    <= req0_wdata;
              m_bus_sel  <= req0_bus;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          m_start <= 1'b1;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // The response pulse is raised on the way into RESPOND so it lands
          // one cycle after m_done.
          if (m_done) begin
            resp_rdata  <= m_rdata;
            resp_nack   <= m_nack;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
            state       <= RESPOND;
          end else if (tmo_hit) begin
            resp_rdata  <= '0;
            resp_nack   <= 1'b1;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
            state       <= RESPOND;
          end
        end
        RESPOND: begin
          last_grant <= grant_id;
          gap_cnt    <= '0;
          state      <= (BUS_FREE_CYCLES > 0) ? GAP : IDLE;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed, scoreboard-based bench for i2c_txn_scheduler.
// Build with +define+I2C_SCHED_TIMEOUT_EN to exercise the watchdog path.
module tb_i2c_txn_scheduler;

  localparam int B   = 8;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic       req0_rw = 1'b0, req1_rw = 1'b0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic       req0_bus = 1'b0, req1_bus = 1'b0;
  logic       resp0_valid, resp1_valid;
  logic [7:0] resp_rdata;
  logic       resp_nack, resp_timeout;
  logic       m_start, m_abort;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_wdata;
  logic       m_bus_sel;
  logic       m_done = 1'b0;
  logic [7:0] m_rdata = '0;
  logic       m_nack = 1'b0;
  logic       busy, grant_id;

  i2c_txn_scheduler #(.BUS_FREE_CYCLES(B), .TIMEOUT_CYCLES(16'(TMO))) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_rw(req0_rw), .req0_wdata(req0_wdata), .req0_bus(req0_bus),
    .resp0_valid(resp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_rw(req1_rw), .req1_wdata(req1_wdata), .req1_bus(req1_bus),
    .resp1_valid(resp1_valid),
    .resp_rdata(resp_rdata), .resp_nack(resp_nack), .resp_timeout(resp_timeout),
    .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_bus_sel(m_bus_sel),
    .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack),
    .busy(busy), .grant_id(grant_id)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       bus;
  } grant_t;

  typedef struct packed {
    logic       id;
    logic [7:0] rdata;
    logic       nack;
    logic       tmo;
  } resp_t;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];
  grant_t g_pop;
  resp_t  r_pop;

  int errors = 0, checks = 0;
  int cyc = 0;
  int rdy_cnt = 0, resp_cnt = 0, abort_cnt = 0;
  int last_start = -1;

  logic [34:0] all_out;
  assign all_out = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata,
                    resp_nack, resp_timeout, m_start, m_abort, m_addr, m_rw,
                    m_wdata, m_bus_sel, busy, grant_id};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: every pulse is matched against the queued expectations.
  always @(negedge clk) begin
    if (req0_ready || req1_ready) begin
      rdy_cnt++;
      chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      chk("grant_id_matches_ready", 32'(grant_id), 32'(req1_ready));
      chk("grant_expected", 32'(exp_grant.size() != 0), 32'd1);
      if (exp_grant.size() != 0) begin
        g_pop = exp_grant.pop_front();
        chk("grant_descriptor", 32'({req1_ready, m_addr, m_rw, m_wdata, m_bus_sel}), 32'(g_pop));
      end
    end
    if (m_start) begin
      if (last_start >= 0)
        chk("start_spacing", 32'((cyc - last_start) >= B + 3), 32'd1);
      last_start = cyc;
    end
    if (resp0_valid || resp1_valid) begin
      resp_cnt++;
      chk("resp_onehot", 32'(resp0_valid & resp1_valid), 32'd0);
      chk("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
      if (exp_resp.size() != 0) begin
        r_pop = exp_resp.pop_front();
        chk("resp_payload", 32'({resp1_valid, resp_rdata, resp_nack, resp_timeout}), 32'(r_pop));
      end
    end
    if (m_abort) abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      step();
      if (m_start) ok = 1'b1;
    end
    chk("m_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 500 && !idle; k++) begin
      step();
      if (!busy) idle = 1'b1;
    end
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  // Engine model: answer dly cycles after m_start; returns in the RESPOND cycle.
  task automatic serve(input int dly, input logic [7:0] rd, input logic nk, input logic id);
    bit ok;
    wait_start(ok);
    if (ok) begin
      repeat (dly) step();
      exp_resp.push_back(resp_t'{id, rd, nk, 1'b0});
      m_rdata = rd; m_nack = nk; m_done = 1'b1;
      step();
      m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
    end
  endtask

  initial begin
    bit ok, bad, found;
    int t0, base;

    // Long reset with a pending request.
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h50; req0_rw = 1'b0; req0_wdata = 8'hA5; req0_bus = 1'b1;
    bad = 1'b0;
    repeat (1000) begin
      step();
      if (all_out !== '0) bad = 1'b1;
    end
    chk("reset_outputs_zero", 32'(bad), 32'd0);
    chk("reset_no_ready", 32'(rdy_cnt), 32'd0);

    exp_grant.push_back(grant_t'{1'b0, 7'h50, 1'b0, 8'hA5, 1'b1});
    reset = 1'b1;
    step();
    chk("accept_first_cycle", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    step();
    chk("start_after_accept", 32'(m_start), 32'd1);
    chk("ready_one_cycle", 32'(req0_ready), 32'd0);
    repeat (20) step();
    exp_resp.push_back(resp_t'{1'b0, 8'h00, 1'b0, 1'b0});
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    chk("resp0_after_done", 32'(resp0_valid), 32'd1);
    chk("resp1_quiet", 32'(resp1_valid), 32'd0);
    chk("resp_nack_clear", 32'(resp_nack), 32'd0);
    chk("m_fields_held", 32'({m_addr, m_wdata, m_bus_sel}), 32'({7'h50, 8'hA5, 1'b1}));

    // m_done while in GAP must not produce a response.
    step(); step();
    m_done = 1'b1; m_rdata = 8'hFF;
    step();
    m_done = 1'b0; m_rdata = '0;
    wait_idle();
    chk("stray_done_ignored", 32'(resp_cnt), 32'd1);

    // Both requesters valid from reset release: strict alternation.
    reset = 1'b0;
    step(); step();
    req0_addr = 7'h11; req0_rw = 1'b0; req0_wdata = 8'h5A; req0_bus = 1'b0;
    req1_addr = 7'h22; req1_rw = 1'b1; req1_wdata = 8'hC3; req1_bus = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_grant.push_back(grant_t'{1'b0, 7'h11, 1'b0, 8'h5A, 1'b0});
      else            exp_grant.push_back(grant_t'{1'b1, 7'h22, 1'b1, 8'hC3, 1'b1});
    end
    base = rdy_cnt;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic id;
      id = (i % 2 == 1);
      serve(i * 3, id ? 8'h3C : 8'h00, id, id);
      chk("resp_owner", 32'({resp1_valid, resp0_valid}), id ? 32'd2 : 32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();
    chk("resp_rdata_hold", 32'(resp_rdata), 32'h3C);
    chk("resp_nack_hold", 32'(resp_nack), 32'd1);
    wait_idle();
    chk("rr_grant_count", 32'(rdy_cnt - base), 32'd4);
    chk("rr_grants_consumed", 32'(exp_grant.size()), 32'd0);

`ifdef I2C_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog abort after TMO cycles.
    req0_addr = 7'h33; req0_rw = 1'b1; req0_wdata = 8'h00; req0_bus = 1'b0;
    exp_grant.push_back(grant_t'{1'b0, 7'h33, 1'b1, 8'h00, 1'b0});
    req0_valid = 1'b1;
    wait_start(ok);
    req0_valid = 1'b0;
    t0 = cyc;
    base = resp_cnt;
    exp_resp.push_back(resp_t'{1'b0, 8'h00, 1'b1, 1'b1});
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (m_abort) found = 1'b1;
    end
    chk("abort_seen", 32'(found), 32'd1);
    chk("abort_latency", 32'(cyc - t0), 32'(TMO));
    chk("abort_resp0", 32'(resp0_valid), 32'd1);
    chk("abort_fields", 32'({resp_timeout, resp_nack, resp_rdata}), 32'({1'b1, 1'b1, 8'h00}));
    step();
    chk("abort_one_cycle", 32'(m_abort), 32'd0);
    m_done = 1'b1; m_rdata = 8'hEE;
    step();
    m_done = 1'b0; m_rdata = '0;
    repeat (3) step();
    chk("late_done_ignored", 32'(resp_cnt), 32'(base + 1));
    chk("timeout_held", 32'(resp_timeout), 32'd1);
    chk("abort_count", 32'(abort_cnt), 32'd1);
    wait_idle();
`else
    // Without the watchdog the engine may take arbitrarily long.
    req0_addr = 7'h33; req0_rw = 1'b1; req0_wdata = 8'h00; req0_bus = 1'b0;
    exp_grant.push_back(grant_t'{1'b0, 7'h33, 1'b1, 8'h00, 1'b0});
    req0_valid = 1'b1;
    wait_start(ok);
    req0_valid = 1'b0;
    base = resp_cnt;
    repeat (150) step();
    chk("no_abort", 32'(abort_cnt), 32'd0);
    chk("still_waiting", 32'(busy), 32'd1);
    chk("no_early_resp", 32'(resp_cnt), 32'(base));
    exp_resp.push_back(resp_t'{1'b0, 8'h99, 1'b0, 1'b0});
    m_done = 1'b1; m_rdata = 8'h99;
    step();
    m_done = 1'b0; m_rdata = '0;
    chk("slow_resp0", 32'(resp0_valid), 32'd1);
    chk("no_timeout_flag", 32'(resp_timeout), 32'd0);
    wait_idle();
`endif

    // Reset in WAIT_DONE drops the transaction silently.
    req1_addr = 7'h44; req1_rw = 1'b1; req1_wdata = 8'h00; req1_bus = 1'b1;
    exp_grant.push_back(grant_t'{1'b1, 7'h44, 1'b1, 8'h00, 1'b1});
    req1_valid = 1'b1;
    wait_start(ok);
    req1_valid = 1'b0;
    base = resp_cnt;
    t0 = abort_cnt;
    repeat (5) step();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    m_done = 1'b1; m_rdata = 8'h77;
    step();
    m_done = 1'b0; m_rdata = '0;
    repeat (5) step();
    chk("reset_drop_no_resp", 32'(resp_cnt), 32'(base));
    chk("reset_drop_no_abort", 32'(abort_cnt), 32'(t0));
    chk("reset_drop_idle", 32'(busy), 32'd0);
    chk("reset_drop_outputs", 32'(all_out), 32'd0);
    chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
